// File: rtl/imm_decode_stage_pkg.sv
// Shared types and encodings for the immediate-extraction stage.
package imm_decode_stage_pkg;

  // Immediate format tag carried alongside every decoded instruction.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CI   = 3'd6,
    FMT_CMEM = 3'd7
  } imm_fmt_e;

  // RV32 base opcodes that carry an immediate.
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Compressed quadrants; 2'b11 marks a full-width instruction.
  localparam logic [1:0] RVC_Q0   = 2'b00;
  localparam logic [1:0] RVC_Q1   = 2'b01;
  localparam logic [1:0] RVC_FULL = 2'b11;

  // Compressed funct3 values (instr[15:13]) that carry an immediate.
  localparam logic [2:0] C_F3_ADDI = 3'b000;
  localparam logic [2:0] C_F3_LI   = 3'b010;
  localparam logic [2:0] C_F3_LW   = 3'b010;
  localparam logic [2:0] C_F3_SW   = 3'b110;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;

  function automatic logic fmt_has_imm(input imm_fmt_e fmt);
    return fmt != FMT_NONE;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Stream bundle for the immediate-extraction stage.
// Handshake: a beat transfers on a posedge where valid and ready are both 1;
// the producer holds valid and payload steady until that edge, and ready never
// depends combinationally on the same side's valid.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import imm_decode_stage_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic            out_has_imm;

  // Environment side: feeds instructions and consumes results.
  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_fmt, out_has_imm
  );

  // Stage side.
  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_fmt, out_has_imm
  );
endinterface

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational immediate extraction for RV32 and optional RVC encodings.
module imm_decode_stage_imm_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit SUPPORT_RVC = 1'b0
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  // Every format is first built as a correctly extended 32-bit value; the
  // compressed memory offset is non-negative so bit 31 stays 0 (zero-extend).
  logic [31:0] imm32;

  // Select the format by opcode (or compressed quadrant/funct3) and build it.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
    if (instr[1:0] == RVC_FULL) begin
      case (instr[6:0])
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          fmt   = FMT_I;
        end
        OP_STORE: begin
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          fmt   = FMT_S;
        end
        OP_BRANCH: begin
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt   = FMT_B;
        end
        OP_LUI, OP_AUIPC: begin
          imm32 = {instr[31:12], 12'b0};
          fmt   = FMT_U;
        end
        OP_JAL: begin
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt   = FMT_J;
        end
        default: ;
      endcase
    end else if (SUPPORT_RVC) begin
      if (instr[1:0] == RVC_Q1 && (instr[15:13] == C_F3_ADDI || instr[15:13] == C_F3_LI)) begin
        imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
        fmt   = FMT_CI;
      end else if (instr[1:0] == RVC_Q0 && (instr[15:13] == C_F3_LW || instr[15:13] == C_F3_SW)) begin
        imm32 = {25'b0, instr[5], instr[12:10], instr[6], 2'b00};
        fmt   = FMT_CMEM;
      end else if (instr[1:0] == RVC_Q1 && instr[15:13] == C_F3_J) begin
        imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                 instr[2], instr[11], instr[5:3], 1'b0};
        fmt   = FMT_J;
      end else if (instr[1:0] == RVC_Q1 &&
                   (instr[15:13] == C_F3_BEQZ || instr[15:13] == C_F3_BNEZ)) begin
        imm32 = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
        fmt   = FMT_B;
      end
    end
  end

  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32[XLEN-1:0];
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-extraction stage with a two-entry skid buffer.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit SUPPORT_RVC = 1'b0
) (
  input logic               clk,
  input logic               rst,
  imm_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
  } entry_t;

  logic [XLEN-1:0] new_imm;
  imm_fmt_e        new_fmt;
  entry_t          new_entry;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            accept;
  logic            drain;

  imm_decode_stage_imm_extract #(
    .XLEN        (XLEN),
    .SUPPORT_RVC (SUPPORT_RVC)
  ) u_extract (
    .instr (bus.in_instr),
    .imm   (new_imm),
    .fmt   (new_fmt)
  );

  assign new_entry = '{instr: bus.in_instr, imm: new_imm, fmt: new_fmt};

  // Ready only reflects the registered skid occupancy, forced low in reset.
  assign bus.in_ready = ~skid_valid & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = main_valid & bus.out_ready;

  // Main register feeds the outputs; skid catches the beat accepted while
  // main is stalled and refills main once it drains, preserving order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (drain) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        main_q     <= new_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= new_entry;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = main_valid;
  assign bus.out_instr   = main_q.instr;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_has_imm = fmt_has_imm(main_q.fmt);

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: one RV32 build without RVC and one RV64 build
// with RVC, driven by the same stream and checked against a reference model.
module tb_imm_decode_stage;
  import imm_decode_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  imm_decode_stage_if #(.XLEN(32)) bus_a ();
  imm_decode_stage_if #(.XLEN(64)) bus_b ();

  assign bus_a.flush     = flush;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_instr  = in_instr;
  assign bus_a.out_ready = out_ready;
  assign bus_b.flush     = flush;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_instr  = in_instr;
  assign bus_b.out_ready = out_ready;

  imm_decode_stage #(.XLEN(32), .SUPPORT_RVC(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  imm_decode_stage #(.XLEN(64), .SUPPORT_RVC(1'b1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates computed arithmetically from field weights.
  function automatic void ref_dec(input logic [31:0] i, input bit rvc,
                                  output logic [63:0] imm, output imm_fmt_e fmt);
    int     s;
    longint v;
    logic [15:0] c;
    s   = int'(i);
    c   = i[15:0];
    v   = 0;
    fmt = FMT_NONE;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h13, 7'h03, 7'h67, 7'h73: begin v = longint'(s >>> 20); fmt = FMT_I; end
        7'h23: begin
          v = longint'(((s >>> 25) <<< 5) | int'(i[11:7]));
          fmt = FMT_S;
        end
        7'h63: begin
          v = longint'(((s >>> 31) <<< 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5)
                       | (int'(i[11:8]) << 1));
          fmt = FMT_B;
        end
        7'h37, 7'h17: begin v = longint'(int'(i & 32'hFFFFF000)); fmt = FMT_U; end
        7'h6F: begin
          v = longint'(((s >>> 31) <<< 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11)
                       | (int'(i[30:21]) << 1));
          fmt = FMT_J;
        end
        default: ;
      endcase
    end else if (rvc) begin
      if (c[1:0] == 2'b01 && (c[15:13] == 3'd0 || c[15:13] == 3'd2)) begin
        v = longint'(c[6:2]) - (c[12] ? 64'sd32 : 64'sd0);
        fmt = FMT_CI;
      end else if (c[1:0] == 2'b00 && (c[15:13] == 3'd2 || c[15:13] == 3'd6)) begin
        v = longint'(c[5]) * 64 + longint'(c[12:10]) * 8 + longint'(c[6]) * 4;
        fmt = FMT_CMEM;
      end else if (c[1:0] == 2'b01 && c[15:13] == 3'd5) begin
        v = -longint'(c[12]) * 2048 + longint'(c[8]) * 1024 + longint'(c[10:9]) * 256
            + longint'(c[6]) * 128 + longint'(c[7]) * 64 + longint'(c[2]) * 32
            + longint'(c[11]) * 16 + longint'(c[5:3]) * 2;
        fmt = FMT_J;
      end else if (c[1:0] == 2'b01 && (c[15:13] == 3'd6 || c[15:13] == 3'd7)) begin
        v = -longint'(c[12]) * 256 + longint'(c[6:5]) * 64 + longint'(c[2]) * 32
            + longint'(c[11:10]) * 8 + longint'(c[4:3]) * 2;
        fmt = FMT_B;
      end
    end
    imm = v;
  endfunction

  // Occupancy model: one entry per accepted beat, out_valid iff non-empty,
  // in_ready iff fewer than two entries held.
  task automatic model_step(input int which, input string tag, input int xlen, input bit rvc,
                            input logic ov, input logic ir, input logic [31:0] oi,
                            input logic [63:0] oimm, input logic [2:0] ofmt, input logic ohas);
    logic [31:0] q[$];
    logic [63:0] eimm;
    imm_fmt_e    efmt;
    int          occ;
    if (which == 0) q = exp_q_a; else q = exp_q_b;
    occ = q.size();
    check({tag, "_out_valid"}, 64'(ov), 64'(occ != 0));
    check({tag, "_in_ready"}, 64'(ir), 64'(!rst && occ < 2));
    if (occ != 0 && ov) begin
      ref_dec(q[0], rvc, eimm, efmt);
      if (xlen == 32) eimm = {32'b0, eimm[31:0]};
      check({tag, "_out_instr"}, 64'(oi), 64'(q[0]));
      check({tag, "_out_imm"}, oimm, eimm);
      check({tag, "_out_fmt"}, 64'(ofmt), 64'(efmt));
      check({tag, "_out_has_imm"}, 64'(ohas), 64'(efmt != FMT_NONE));
    end
    if (occ != 0 && out_ready) void'(q.pop_front());
    if (rst || flush) q.delete();
    else if (in_valid && occ < 2) q.push_back(in_instr);
    if (which == 0) exp_q_a = q; else exp_q_b = q;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    model_step(0, "a", 32, 1'b0, bus_a.out_valid, bus_a.in_ready, bus_a.out_instr,
               64'(bus_a.out_imm), bus_a.out_fmt, bus_a.out_has_imm);
    model_step(1, "b", 64, 1'b1, bus_b.out_valid, bus_b.in_ready, bus_b.out_instr,
               bus_b.out_imm, bus_b.out_fmt, bus_b.out_has_imm);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] ins,
                          input logic [63:0] ia, input logic [2:0] fa,
                          input logic [63:0] ib, input logic [2:0] fb);
    in_valid  = 1'b1;
    in_instr  = ins;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check({tag, "_valid_a"}, 64'(bus_a.out_valid), 64'd1);
    check({tag, "_imm_a"}, 64'(bus_a.out_imm), ia);
    check({tag, "_fmt_a"}, 64'(bus_a.out_fmt), 64'(fa));
    check({tag, "_imm_b"}, bus_b.out_imm, ib);
    check({tag, "_fmt_b"}, 64'(bus_b.out_fmt), 64'(fb));
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_a"}, 64'(bus_a.out_valid), 64'd0);
    check({tag, "_imm_a"}, 64'(bus_a.out_imm), 64'd0);
    check({tag, "_fmt_a"}, 64'(bus_a.out_fmt), 64'(FMT_NONE));
    check({tag, "_instr_a"}, 64'(bus_a.out_instr), 64'd0);
    check({tag, "_has_a"}, 64'(bus_a.out_has_imm), 64'd0);
    check({tag, "_ready_a"}, 64'(bus_a.in_ready), 64'd0);
    check({tag, "_valid_b"}, 64'(bus_b.out_valid), 64'd0);
    check({tag, "_imm_b"}, bus_b.out_imm, 64'd0);
    check({tag, "_fmt_b"}, 64'(bus_b.out_fmt), 64'(FMT_NONE));
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] up;
    logic [6:0]  op;
    int          r;
    up = $urandom;
    r  = $urandom_range(0, 12);
    case (r)
      0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h73;
      4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h6F;  9: op = 7'h33;
      default: op = 7'h00;
    endcase
    if (r <= 9) return {up[31:7], op};
    if (r <= 11) return {up[31:2], 2'($urandom_range(0, 2))};
    return up;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    bit was_acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (3) cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(bus_a.in_ready), 64'd1);

    directed("addi_m1", 32'hFFF00093, 64'hFFFF_FFFF, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    directed("lui", 32'h123450B7, 64'h1234_5000, FMT_U, 64'h1234_5000, FMT_U);
    directed("add", 32'h00000033, 64'd0, FMT_NONE, 64'd0, FMT_NONE);
    directed("jal_m4", 32'hFFDFF06F, 64'hFFFF_FFFC, FMT_J, 64'hFFFF_FFFF_FFFF_FFFC, FMT_J);
    directed("c_li_m1", 32'h000050FD, 64'd0, FMT_NONE, 64'hFFFF_FFFF_FFFF_FFFF, FMT_CI);

    // Backpressure: A, B accepted into main/skid, C held, then drained in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    cycle();
    in_instr  = 32'h00A12023;
    cycle();
    in_instr  = 32'hFE000EE3;
    check("bp_in_ready_low", 64'(bus_a.in_ready), 64'd0);
    cycle();
    check("bp_c_held", 64'(bus_a.out_instr), 64'h00500093);
    out_ready = 1'b1;
    cycle();
    check("bp_b_next", 64'(bus_a.out_instr), 64'h00A12023);
    cycle();
    in_valid = 1'b0;
    check("bp_c_last", 64'(bus_a.out_instr), 64'hFE000EE3);
    cycle();
    check("bp_empty", 64'(bus_a.out_valid), 64'd0);

    // Flush with both entries full and a beat offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100113;
    cycle();
    in_instr  = 32'h00200193;
    cycle();
    flush    = 1'b1;
    in_instr = 32'h00300213;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(bus_b.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus_b.in_ready), 64'd1);
    out_ready = 1'b1;
    cycle();
    check("flush_no_beat", 64'(bus_a.out_valid), 64'd0);

    // Random traffic with payload held while stalled.
    was_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!(in_valid && !was_acc && !flush)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = gen_instr();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      was_acc   = in_valid && bus_a.in_ready;
      cycle();
    end
    flush = 1'b0;

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h7FF00513;
    cycle();
    in_instr  = 32'h80000537;
    cycle();
    rst = 1'b1;
    cycle();
    check_reset_outputs("mid_reset");
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
